// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory
// under a credit limit, and buffers in-order responses for the decode stage.
module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   buf_addr_q [FIFO_DEPTH];
  logic [31:0]   buf_inst_q [FIFO_DEPTH];
  logic [31:0]   tag_q      [FIFO_DEPTH];

  logic credit_ok, grant, resp, drop, push, pop;

  // A pop in this cycle does not return a credit; buffered words still count.
  assign credit_ok    = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W;
  assign imem_req_o   = !rst && !redirect_i && credit_ok;
  assign imem_addr_o  = pc_q;
  assign grant        = imem_req_o && imem_gnt_i;
  assign resp         = imem_rvalid_i && (inflight_q != '0);
  assign drop         = redirect_i || (discard_q != '0);
  assign push         = resp && !drop;
  assign pop          = inst_valid_o && !stall_i && !redirect_i;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? buf_inst_q[rd_ptr_q] : NOP;
  assign inst_addr_o  = inst_valid_o ? buf_addr_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(grant) - CW'(resp);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_wr_d   = tag_wr_q + PW'(grant);
    tag_rd_d   = tag_rd_q + PW'(resp);
    if (redirect_i) begin
      pc_d      = {redirect_addr_i[31:2], 2'b00};
      // Every request still outstanding after this cycle belongs to the old path.
      discard_d = inflight_q - CW'(resp);
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_inst_q[i] <= '0;
        tag_q[i]      <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      if (grant) tag_q[tag_wr_q] <= pc_q;
      if (push) begin
        buf_addr_q[wr_ptr_q] <= tag_q[tag_rd_q];
        buf_inst_q[wr_ptr_q] <= imem_rdata_i;
      end
    end
  end

  a_rvalid_has_inflight: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (inflight_q != '0));

endmodule
